// File: rtl/md_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit:
// MDOp encoding, default latencies and the HI/LO pair type.
package md_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  localparam int MD_MULT_LAT = 5;
  localparam int MD_DIV_LAT  = 10;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

endpackage

// File: rtl/md_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
// Results are computed at issue and committed when the latency counter expires.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_LAT = MD_MULT_LAT,
  parameter int DIV_LAT  = MD_DIV_LAT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDOp,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  logic [CW-1:0] cnt;
  hilo_t         hilo;
  hilo_t         pend;
  logic          pend_wr;

  logic [63:0]   prod_s;
  logic [63:0]   prod_u;
  logic [31:0]   quo_s, rem_s, quo_u, rem_u;
  logic          div_ovf;
  hilo_t         issue_res;
  logic          issue_wr;

  always_comb begin
    prod_s  = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    prod_u  = {32'd0, A} * {32'd0, B};
    div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    quo_s   = '0;
    rem_s   = '0;
    quo_u   = '0;
    rem_u   = '0;
    // Divide by zero leaves the quotient paths at 0; the commit is suppressed anyway.
    if (B != '0) begin
      quo_u = A / B;
      rem_u = A % B;
      if (div_ovf) begin
        quo_s = A;
        rem_s = '0;
      end else begin
        quo_s = $signed(A) / $signed(B);
        rem_s = $signed(A) % $signed(B);
      end
    end
  end

  always_comb begin
    issue_res = '0;
    issue_wr  = 1'b0;
    case (MDOp)
      MD_MULT:  begin issue_res = prod_s;         issue_wr = 1'b1;       end
      MD_MULTU: begin issue_res = prod_u;         issue_wr = 1'b1;       end
      MD_DIV:   begin issue_res = {rem_s, quo_s}; issue_wr = (B != '0); end
      MD_DIVU:  begin issue_res = {rem_u, quo_u}; issue_wr = (B != '0); end
      default:  ;
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      hilo    <= '0;
      pend    <= '0;
      pend_wr <= 1'b0;
    end else if (cnt == '0) begin
      if (Start) begin
        case (MDOp)
          MD_MULT, MD_MULTU: begin
            cnt     <= CW'(MULT_LAT);
            pend    <= issue_res;
            pend_wr <= issue_wr;
          end
          MD_DIV, MD_DIVU: begin
            cnt     <= CW'(DIV_LAT);
            pend    <= issue_res;
            pend_wr <= issue_wr;
          end
          MD_MTHI: hilo.hi <= A;
          MD_MTLO: hilo.lo <= A;
          default: ;
        endcase
      end
    end else begin
      // Any Start while running is a stall violation and is dropped here.
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1) && pend_wr)
        hilo <= pend;
    end
  end

  assign Busy = (cnt != '0);
  assign HI   = hilo.hi;
  assign LO   = hilo.lo;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: scoreboard of expected {HI,LO} and busy
// length pushed at issue, popped when Busy falls.
module tb_md_unit;
  import md_pkg::*;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] A     = '0;
  logic [31:0] B     = '0;
  logic [2:0]  MDOp  = MD_NONE;
  logic        Start = 1'b0;
  logic        Busy;
  logic [31:0] HI, LO;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [63:0] hilo;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] cur = '0;

  always #5 clk = ~clk;

  md_unit #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .MDOp(MDOp),
    .Start(Start), .Busy(Busy), .HI(HI), .LO(LO)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Reference model: sign-magnitude division, 64-bit products.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] prev);
    longint sa, sbv, ma, mb, q, r;
    logic [63:0] res;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    res = prev;
    case (op)
      MD_MULT:  res = 64'(sa * sbv);
      MD_MULTU: res = {32'd0, a} * {32'd0, b};
      MD_DIV: if (b != 0) begin
        ma = (sa < 0) ? -sa : sa;
        mb = (sbv < 0) ? -sbv : sbv;
        q  = ma / mb;
        r  = ma % mb;
        if ((sa < 0) != (sbv < 0)) q = -q;
        if (sa < 0) r = -r;
        res = {r[31:0], q[31:0]};
      end
      MD_DIVU: if (b != 0) res = {a % b, a / b};
      default: ;
    endcase
    return res;
  endfunction

  // Drive a one-cycle Start; caller is positioned away from the rising edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    MDOp  = op;
    A     = a;
    B     = b;
    Start = 1'b1;
    @(posedge clk);
    #1;
    Start = 1'b0;
    MDOp  = MD_NONE;
  endtask

  task automatic issue_push(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] exp_hilo);
    exp_t e;
    e.hilo = exp_hilo;
    e.lat  = (op == MD_MULT || op == MD_MULTU) ? 5 : 10;
    sb.push_back(e);
    cur = exp_hilo;
    issue(op, a, b);
  endtask

  // Counts Busy=1 cycles sampled on falling edges; -1 on timeout.
  task automatic run_until_idle(output int cycles);
    cycles = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!Busy) return;
      cycles++;
    end
    cycles = -1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    vectors++; if (HI !== 32'd0)  begin miscompares++; $display("FAIL reset_hi: got %h want 0", HI); end
    vectors++; if (LO !== 32'd0)  begin miscompares++; $display("FAIL reset_lo: got %h want 0", LO); end
    vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", Busy); end
    @(negedge clk);
    rst_n = 1'b1;
    cur   = '0;
  endtask

  task automatic test_mult_div;
    logic [2:0]  ops[5]  = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_DIV};
    logic [31:0] as[5]   = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000};
    logic [31:0] bs[5]   = '{32'd3, 32'd3, 32'd2, 32'd2, 32'hFFFF_FFFF};
    logic [63:0] exps[5] = '{64'hFFFF_FFFF_FFFF_FFFA, 64'h0000_0002_FFFF_FFFA,
                             64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0001_0000_0003,
                             64'h0000_0000_8000_0000};
    int    c;
    exp_t  e;
    for (int i = 0; i < 11; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      logic [63:0] x;
      if (i < 5) begin
        op = ops[i]; a = as[i]; b = bs[i]; x = exps[i];
      end else begin
        op = 3'(1 + $urandom_range(0, 3));
        a  = $urandom;
        b  = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
        x  = model(op, a, b, cur);
      end
      @(negedge clk);
      issue_push(op, a, b, x);
      run_until_idle(c);
      e = sb.pop_front();
      vectors++; if (c !== e.lat) begin miscompares++; $display("FAIL md_lat[%0d] op=%0d: busy %0d cycles want %0d", i, op, c, e.lat); end
      vectors++; if ({HI, LO} !== e.hilo) begin miscompares++; $display("FAIL md_res[%0d] op=%0d a=%h b=%h: got %h want %h", i, op, a, b, {HI, LO}, e.hilo); end
    end
  endtask

  task automatic test_div_zero;
    int   c;
    exp_t e;
    @(negedge clk);
    issue(MD_MTHI, 32'h11, 32'd0);
    issue(MD_MTLO, 32'h22, 32'd0);
    @(negedge clk);
    vectors++; if ({HI, LO} !== 64'h0000_0011_0000_0022) begin miscompares++; $display("FAIL preload: got %h want 0000001100000022", {HI, LO}); end
    cur = 64'h0000_0011_0000_0022;
    for (int k = 0; k < 2; k++) begin
      issue_push(k == 0 ? MD_DIV : MD_DIVU, 32'h1234, 32'd0, cur);
      run_until_idle(c);
      e = sb.pop_front();
      vectors++; if (c !== 10) begin miscompares++; $display("FAIL divzero_lat[%0d]: busy %0d want 10", k, c); end
      vectors++; if ({HI, LO} !== e.hilo) begin miscompares++; $display("FAIL divzero_res[%0d]: got %h want %h", k, {HI, LO}, e.hilo); end
    end
  endtask

  task automatic test_mt;
    int   c;
    logic busy_seen;
    exp_t e;
    @(negedge clk);
    issue(MD_MTHI, 32'hDEAD_BEEF, 32'd0);
    busy_seen = Busy;
    @(negedge clk);
    busy_seen = busy_seen | Busy;
    vectors++; if (HI !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL mthi: got %h want deadbeef", HI); end
    vectors++; if (busy_seen !== 1'b0) begin miscompares++; $display("FAIL mthi_busy: got %b want 0", busy_seen); end
    // MTLO issued during RUN must be dropped; the MULT result wins.
    issue_push(MD_MULT, 32'd6, 32'd7, 64'd42);
    c = 0;
    for (int i = 0; i < 100 && c >= 0; i++) begin
      @(negedge clk);
      if (!Busy) break;
      c++;
      Start = (c == 2);
      MDOp  = (c == 2) ? MD_MTLO : MD_NONE;
      A     = 32'h5555_5555;
      if (i == 99) c = -1;
    end
    Start = 1'b0;
    e = sb.pop_front();
    vectors++; if (c !== e.lat) begin miscompares++; $display("FAIL mtlo_run_lat: busy %0d want %0d", c, e.lat); end
    vectors++; if ({HI, LO} !== e.hilo) begin miscompares++; $display("FAIL mtlo_run_res: got %h want %h", {HI, LO}, e.hilo); end
  endtask

  task automatic test_back_to_back;
    int   c;
    exp_t e;
    @(negedge clk);
    issue_push(MD_MULT, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);
    run_until_idle(c);
    e = sb.pop_front();
    vectors++; if (c !== e.lat) begin miscompares++; $display("FAIL b2b_mult_lat: busy %0d want %0d", c, e.lat); end
    vectors++; if ({HI, LO} !== e.hilo) begin miscompares++; $display("FAIL b2b_mult_res: got %h want %h", {HI, LO}, e.hilo); end
    // Issue on the very first Busy=0 cycle; a stray MULT mid-run must not disturb it.
    issue_push(MD_DIVU, 32'd100, 32'd7, 64'h0000_0002_0000_000E);
    c = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!Busy) break;
      c++;
      Start = (c == 3);
      MDOp  = (c == 3) ? MD_MULT : MD_NONE;
      A     = 32'hFFFF_FFFF;
      B     = 32'hFFFF_FFFF;
      if (i == 99) c = -1;
    end
    Start = 1'b0;
    e = sb.pop_front();
    vectors++; if (c !== e.lat) begin miscompares++; $display("FAIL b2b_div_lat: busy %0d want %0d", c, e.lat); end
    vectors++; if ({HI, LO} !== e.hilo) begin miscompares++; $display("FAIL b2b_div_res: got %h want %h", {HI, LO}, e.hilo); end
  endtask

  task automatic test_reset_mid_div;
    logic busy_seen;
    @(negedge clk);
    issue(MD_MTHI, 32'hAAAA_0001, 32'd0);
    issue(MD_MTLO, 32'hBBBB_0002, 32'd0);
    issue(MD_DIV, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_busy: got %b want 0", Busy); end
    vectors++; if ({HI, LO} !== 64'd0) begin miscompares++; $display("FAIL rst_mid_hilo: got %h want 0", {HI, LO}); end
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    busy_seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      busy_seen = busy_seen | Busy;
    end
    vectors++; if (busy_seen !== 1'b0) begin miscompares++; $display("FAIL rst_mid_late_busy: got %b want 0", busy_seen); end
    vectors++; if ({HI, LO} !== 64'd0) begin miscompares++; $display("FAIL rst_mid_late_commit: got %h want 0", {HI, LO}); end
    cur = '0;
  endtask

  initial begin
    test_reset;
    test_mult_div;
    test_div_zero;
    test_mt;
    test_back_to_back;
    test_reset_mid_div;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Execute-stage multiply/divide unit: the multi-cycle neighbour of `alu`. It consumes the same forwarded E-stage operands A/B, computes MULT/MULTU/DIV/DIVU into architectural HI/LO, and handles MTHI/MTLO. Its HI/LO outputs feed the E-stage result mux (MFHI/MFLO path) alongside the ALU result C, ahead of the EX/MEM register. `Busy` drives the hazard unit's stall logic.

## Interface
- `MULT_LAT`, default 5: cycles Busy stays high for MULT/MULTU.
- `DIV_LAT`, default 10: cycles Busy stays high for DIV/DIVU.

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous active-low reset.
- `A` input 32: rs operand (dividend / multiplicand / MTHI-MTLO source).
- `B` input 32: rt operand (divisor / multiplier).
- `MDOp` input 3: operation code, sampled only when Start=1.
- `Start` input 1: issue strobe, one cycle per instruction.
- `Busy` output 1: operation in flight.
- `HI` output 32: architectural HI register.
- `LO` output 32: architectural LO register.

## Operation
- MDOp encoding: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
- Reset (async, rst_n=0): HI=0, LO=0, Busy=0, counter=0, pending result cleared. Reset mid-operation aborts the operation and leaves HI/LO=0.
- Two states: IDLE (Busy=0) and RUN (Busy=1), tracked by a down-counter.
- IDLE with Start=1:
  - MULT/MULTU: compute the 64-bit product at issue and hold it in pending registers. MULT is signed × signed; MULTU is unsigned. Load counter=MULT_LAT and go to RUN.
  - DIV/DIVU: pending LO=quotient and HI=remainder. DIV truncates toward zero, and the remainder takes the sign of the dividend. Load counter=DIV_LAT and go to RUN.
  - MTHI/MTLO: write A into HI/LO at that edge. Busy stays 0.
  - NONE/reserved: no effect.
- RUN: counter decrements each edge. On the edge where counter goes 1→0, commit pending {HI,LO} and go to IDLE.
- Start=1 in RUN, any MDOp: ignored. The hazard unit must stall on (Busy | Start&(MDOp∈1..4)), so this is a protocol violation, but the unit must not corrupt state.
- Divide by zero (B=0, DIV or DIVU): full DIV_LAT busy period, HI/LO unchanged at commit.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (wrap, no trap).
- Width rules: products are 64-bit (HI=[63:32], LO=[31:0]). Quotient and remainder are 32-bit. No exceptions are raised.

## Timing
- Start sampled at edge E0 (MULT): Busy=1 in the cycles after E0, E1, E2, E3, E4. At E5, HI/LO update and Busy falls. Busy is high for exactly MULT_LAT cycles; DIV is the same with DIV_LAT.
- MFHI/MFLO issued in the cycle after Busy falls reads the committed value.
- MTHI/MTLO: HI/LO change at E0 and are visible in the next cycle. Latency 1, no busy.
- Back-to-back: a Start in the first cycle with Busy=0 is accepted (0 bubble cycles).
- HI, LO and Busy are registered outputs. There is no combinational path from inputs to outputs.

## Structure
- Shared package `md_pkg`: MDOp encoding constants (MD_NONE…MD_MTLO), default MULT_LAT/DIV_LAT values.
- Single module. Behavioural `*`, `/`, `%` on signed/unsigned casts computed at issue. A latency counter of $clog2(DIV_LAT+1) bits models the hardware timing.
- No sub-module needed.

## Test plan
- Reset: hold rst_n=0, pulse clk → HI=0, LO=0, Busy=0. Assert rst_n=0 mid-DIV (cycle 4) → Busy=0, HI/LO=0 immediately, no later commit.
- MULT A=0xFFFFFFFE (−2), B=3 → Busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. Same operands with MULTU → HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=0xFFFFFFF9 (−7), B=2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=2 → LO=3, HI=1.
- Divide by zero: preload HI=0x11, LO=0x22 via MTHI/MTLO, then DIV B=0 → Busy 10 cycles, HI=0x11, LO=0x22 unchanged. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- MTHI A=0xDEADBEEF → HI=0xDEADBEEF next cycle, Busy never asserted. MTLO during RUN → ignored, and the committed result overrides.
- Back-to-back: MULT then Start DIV on the first Busy=0 cycle → accepted with 0 bubbles, and the second result commits 10 cycles later. A Start issued while Busy=1 has no effect on HI/LO or timing.
